router_pkt_tx: RTL



---
 rtl/router_pkg.sv | 26 ++
 rtl/router_tx_buf.sv | 45 ++++
 rtl/router_pkt_tx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
// Header byte layout: {len[5:0], addr[1:0]}.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int BYTE_W = 8;

  localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } tx_state_t;

  // Router header: length in the upper six bits, destination in the lower two.
  function automatic logic [BYTE_W-1:0] hdr_byte(input logic [ADDR_W-1:0] addr,
                                                 input logic [LEN_W-1:0]  len);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer for router_pkt_tx: synchronous write port, registered read port.
// The read address is the transmitter's next-state read pointer, so the
// registered output always holds the byte that goes out on the next transfer.
// A write to the address being read is forwarded, so a byte accepted on the
// final LOAD cycle is already visible when the header leaves.
module router_tx_buf
  import router_pkg::*;
#(
  parameter int DEPTH = 63
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [LEN_W-1:0]  wr_addr_i,
  input  logic [BYTE_W-1:0] wr_data_i,
  input  logic [LEN_W-1:0]  rd_addr_i,
  output logic [BYTE_W-1:0] rd_data_o
);

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [BYTE_W-1:0] rd_data_q;

  // Storage write; the pointer never reaches DEPTH within a packet.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read with write-forwarding; the pointer one past the last byte
  // reads as zero instead of touching a non-existent entry.
  always_ff @(posedge clock) begin
    if (we_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_q <= wr_data_i;
    end else if (rd_addr_i < DEPTH_L) begin
      rd_data_q <= mem[rd_addr_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input port.
// Buffers a whole payload from an upstream byte stream, then emits
// header / payload / parity on data_out with pkt_valid, stalling on busy.
// Optional build macro ROUTER_TX_PARITY_INJ_EN adds input corrupt_parity,
// sampled when a start is accepted; when set, parity bit 0 is inverted.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  pay_len,
  input  logic [BYTE_W-1:0] pl_data,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic              busy,
`ifdef ROUTER_TX_PARITY_INJ_EN
  input  logic              corrupt_parity,
`endif
  output logic [BYTE_W-1:0] data_out,
  output logic              pkt_valid,
  output logic              tx_active,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [LEN_W-1:0] MAX_LEN_L  = LEN_W'(MAX_LEN);
  // GAP counter is 8 bits wide, so GAP_CYCLES is limited to 1..256.
  localparam logic [7:0]       GAP_LAST   = 8'(GAP_CYCLES - 1);

  tx_state_t         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  wr_ptr_q;
  logic [LEN_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [BYTE_W-1:0] acc_q;
  logic [7:0]        gap_cnt_q;
  logic              corrupt_q;

  logic [BYTE_W-1:0] data_out_q;
  logic              pkt_valid_q;
  logic              pl_ready_q;
  logic              tx_active_q;
  logic              done_q;
  logic              cfg_err_q;

  logic              buf_we;
  logic [BYTE_W-1:0] buf_rd_data;
  logic              cfg_bad;
  logic              xfer;
  logic [BYTE_W-1:0] inj_mask;

  // Request legality: reserved address, empty payload, or oversize payload.
  always_comb begin
    cfg_bad = (dest_addr == ILLEGAL_ADDR) || (pay_len == '0) || (pay_len > MAX_LEN_L);
  end

  // A byte transfers on any edge of an output state with the router not busy.
  always_comb begin
    xfer = ((state_q == HEADER) || (state_q == PAYLOAD) || (state_q == PARITY)) && !busy;
  end

  // Next read pointer: advance on each transfer that presents a new payload byte.
  // Feeding the buffer with the next-state pointer keeps its output one byte ahead.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (reset) begin
      rd_ptr_d = '0;
    end else if ((state_q == IDLE) && start && !cfg_bad) begin
      rd_ptr_d = '0;
    end else if (xfer && (state_q == HEADER)) begin
      rd_ptr_d = rd_ptr_q + LEN_W'(1);
    end else if (xfer && (state_q == PAYLOAD) && (rd_ptr_q != len_q)) begin
      rd_ptr_d = rd_ptr_q + LEN_W'(1);
    end
  end

  assign buf_we = (state_q == LOAD) && pl_valid && pl_ready_q;

`ifdef ROUTER_TX_PARITY_INJ_EN
  assign inj_mask = {{(BYTE_W-1){1'b0}}, corrupt_q};
`else
  assign inj_mask = '0;
`endif

  router_tx_buf #(
    .DEPTH (MAX_LEN)
  ) u_buf (
    .clock     (clock),
    .we_i      (buf_we),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (pl_data),
    .rd_addr_i (rd_ptr_d),
    .rd_data_o (buf_rd_data)
  );

  // Transmit FSM with all outputs registered; busy freezes every output state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      acc_q       <= '0;
      gap_cnt_q   <= '0;
      corrupt_q   <= 1'b0;
      data_out_q  <= '0;
      pkt_valid_q <= 1'b0;
      pl_ready_q  <= 1'b0;
      tx_active_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      rd_ptr_q  <= rd_ptr_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err_q <= 1'b1;
            end else begin
              addr_q      <= dest_addr;
              len_q       <= pay_len;
              wr_ptr_q    <= '0;
              acc_q       <= '0;
`ifdef ROUTER_TX_PARITY_INJ_EN
              corrupt_q   <= corrupt_parity;
`else
              corrupt_q   <= 1'b0;
`endif
              pl_ready_q  <= 1'b1;
              tx_active_q <= 1'b1;
              state_q     <= LOAD;
            end
          end
        end
        LOAD: begin
          if (pl_valid && pl_ready_q) begin
            wr_ptr_q <= wr_ptr_q + LEN_W'(1);
            if (wr_ptr_q == (len_q - LEN_W'(1))) begin
              // Last byte in: header goes out on the very next cycle.
              pl_ready_q  <= 1'b0;
              data_out_q  <= hdr_byte(addr_q, len_q);
              pkt_valid_q <= 1'b1;
              acc_q       <= hdr_byte(addr_q, len_q);
              state_q     <= HEADER;
            end
          end
        end
        HEADER: begin
          if (xfer) begin
            data_out_q <= buf_rd_data;
            state_q    <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            acc_q <= acc_q ^ data_out_q;
            if (rd_ptr_q == len_q) begin
              // Last payload byte leaving: present parity with pkt_valid low.
              data_out_q  <= acc_q ^ data_out_q ^ inj_mask;
              pkt_valid_q <= 1'b0;
              state_q     <= PARITY;
            end else begin
              data_out_q <= buf_rd_data;
            end
          end
        end
        PARITY: begin
          if (xfer) begin
            done_q     <= 1'b1;
            data_out_q <= '0;
            gap_cnt_q  <= '0;
            state_q    <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            tx_active_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign pkt_valid = pkt_valid_q;
  assign pl_ready  = pl_ready_q;
  assign tx_active = tx_active_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule
